tdm_mux4: RTL and testbench
===========================

# tdm_mux4

Four-channel, registered, round-robin time-division multiplexer. It is the gathering end of the lab's 1-to-4 demultiplexer path: four independent valid/ready sources are merged onto one output stream. Each output word is tagged with the 2-bit channel index, so a downstream demux can route it back. It sits between the per-channel producers and the shared serial link.

## Interface
- `W`, default 1: data width per channel.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  4*W  channel data; channel i occupies `[i*W +: W]`.
- `in_valid`  in  4  per-channel data valid.
- `in_ready`  out  4  per-channel accept. A transfer occurs when `in_valid[i] && in_ready[i]`.
- `out_data`  out  W  registered selected data.
- `out_sel`  out  2  registered channel index of `out_data`.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  downstream accept.

## Operation
- **State**
  - `ptr` (2-bit rotation pointer).
  - One output register holding `out_data`, `out_sel` and `out_valid`.
- **Output-stage FSM**
  - EMPTY when `out_valid=0`; FULL when `out_valid=1`.
  - `can_load = !out_valid || out_ready`.
  - EMPTY→FULL on capture.
  - FULL→FULL on capture while `out_ready=1`, giving back-to-back words.
  - FULL→EMPTY when `out_ready=1` and there is no capture.
  - FULL holds unchanged while `out_ready=0`.
- **Slot selection:** `slot` is `ptr` in strict mode; see Configuration for skip mode.
- **Handshake**
  - `in_ready[i] = can_load && (i == slot)`. This is combinational, and at most one bit is high.
  - Capture occurs when `can_load && in_valid[slot]`. The register loads `out_data<=in_data[slot]`, `out_sel<=slot`, `out_valid<=1`.
  - When `can_load` is high and there is no capture, `out_valid<=0`. `out_data` and `out_sel` then hold their old values (don't-care).
- **No loss, no duplication:** when `can_load=0`, all `in_ready` are 0 and `ptr` holds. An input word must stay stable while its valid is high and it is not yet accepted.
- **Wrap-around:** `ptr` increments modulo 4 (3→0).

## Timing
- **Reset values:** `ptr=0`, `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=4'b0001` (strict mode, EMPTY) or `4'b0000` (skip mode, no valid).
- **Latency:** exactly 1 cycle from input acceptance to `out_valid`.
- **Throughput:** 1 word/cycle while `out_ready=1`.
- **Reset mid-operation:** any word held in the output register is discarded, and the pointer returns to 0 on the next edge.
- `out_ready` has no effect while `out_valid=0`.

## Configuration
- **`TDM_MUX4_SKIP_EN` defined (work-conserving):**
  - `slot` is the first channel with `in_valid` high, searching cyclically from `ptr` through `ptr+3`.
  - On capture, `ptr<=slot+1`.
  - If no channel is valid, `in_ready=0` and `ptr` holds.
- **Undefined (strict TDM):**
  - `slot=ptr` whether or not that channel is valid.
  - `ptr<=ptr+1` on every cycle with `can_load=1`, captured or not.
  - An idle slot yields one EMPTY cycle, so bandwidth is fixed at 1/4 per channel.

## Structure
- **Package `tdm_pkg`:** `NCH=4`, `SEL_W=2`, `typedef logic [SEL_W-1:0] sel_t`. The matching demux shares this package.
- **Sub-module `rr_pick4`:** combinational cyclic-priority picker. Inputs are `req[3:0]` and `base`; outputs are `grant_idx` and `any`. It is instantiated only under `TDM_MUX4_SKIP_EN`.
- Everything else is a single always block for the registers plus combinational ready/select logic.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all `in_valid=1`. Require `out_valid=0` and `out_sel=0` during reset. After release, the first output is channel 0 with `out_sel=0`, one cycle later.
- **All channels valid, `out_ready=1`, W=1, data `4'b1010`:** outputs on consecutive cycles have `out_sel` 0,1,2,3,0 and `out_data` 0,1,0,1,0. Each channel's `in_ready` pulses once per 4 cycles.
- **Backpressure:** hold `out_ready=0` for 3 cycles while FULL with `out_sel=2`. Require `out_data` and `out_sel` stable, all `in_ready=0`, and `ptr` frozen. On release, the next word comes from channel 3.
- **Sparse traffic, only `in_valid[2]=1`:**
  - Strict mode: outputs with `out_sel=2` appear every 4th cycle, with `out_valid=0` on the other three.
  - Skip mode: `out_sel=2` on every cycle.
- **Simultaneous drain and load:** FULL with `out_ready=1` and `in_valid[ptr]=1` in the same cycle. Require `out_valid` to stay 1 with the new `out_sel`, and no bubble.
- **Reset while FULL with `out_ready=0`:** the word is dropped, `out_valid=0` on the next cycle, and the pointer restarts at channel 0.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the four-channel TDM mux/demux pair.
// Build option TDM_MUX4_SKIP_EN selects work-conserving slot selection in tdm_mux4.
package tdm_pkg;
   localparam int NCH   = 4;
   localparam int SEL_W = 2;

   typedef logic [SEL_W-1:0] sel_t;

   // Output-stage occupancy; FULL is exactly out_valid=1.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } ostate_t;
endpackage

// File: rtl/tdm_mux4_rr_pick4.sv
// Combinational cyclic-priority picker: first asserted req at or after base,
// wrapping 3->0. Used by tdm_mux4 only when TDM_MUX4_SKIP_EN is defined.
module rr_pick4
   import tdm_pkg::*;
(
   input  logic [3:0] req,
   input  sel_t       base,
   output sel_t       grant_idx,
   output logic       any
);
   sel_t idx;

   // Scan farthest-first so the nearest requester (k=0 is base itself) wins.
   always_comb begin
      grant_idx = base;
      any       = 1'b0;
      idx       = base;
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = base + sel_t'(k);
         if (req[idx]) begin
            grant_idx = idx;
            any       = 1'b1;
         end
      end
   end
endmodule

// File: rtl/tdm_mux4.sv
// Four-channel registered round-robin TDM mux; each word is tagged with its channel.
// Define TDM_MUX4_SKIP_EN for work-conserving selection, otherwise strict TDM slots.
module tdm_mux4
   import tdm_pkg::*;
#(
   parameter int W = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [4*W-1:0] in_data,
   input  logic [3:0]     in_valid,
   output logic [3:0]     in_ready,
   output logic [W-1:0]   out_data,
   output sel_t           out_sel,
   output logic           out_valid,
   input  logic           out_ready
);
   // Handshake: a word moves on any edge where valid && ready are both high;
   // a source holds its data stable while valid is high and ready is low.
   ostate_t        state;
   ostate_t        state_nxt;
   sel_t           ptr;
   sel_t           ptr_nxt;
   sel_t           slot;
   logic           slot_vld;
   logic           can_load;
   logic           capture;
   logic [W-1:0]   slot_data;

`ifdef TDM_MUX4_SKIP_EN
   rr_pick4 u_pick (
      .req       (in_valid),
      .base      (ptr),
      .grant_idx (slot),
      .any       (slot_vld)
   );
`else
   assign slot     = ptr;
   assign slot_vld = 1'b1;
`endif

   assign can_load  = (state == ST_EMPTY) || out_ready;
   assign capture   = can_load && slot_vld && in_valid[slot];
   assign out_valid = (state == ST_FULL);

   always_comb begin
      in_ready  = '0;
      slot_data = in_data[W-1:0];
      for (int i = 0; i < NCH; i++) begin
         if (slot == sel_t'(i)) begin
            in_ready[i] = can_load && slot_vld;
            slot_data   = in_data[i*W +: W];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      if (can_load) begin
         state_nxt = capture ? ST_FULL : ST_EMPTY;
`ifdef TDM_MUX4_SKIP_EN
         if (capture) ptr_nxt = slot + sel_t'(1);
`else
         // Strict TDM: the slot is consumed even when its channel is idle.
         ptr_nxt = ptr + sel_t'(1);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_EMPTY;
         ptr      <= '0;
         out_data <= '0;
         out_sel  <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         if (capture) begin
            out_data <= slot_data;
            out_sel  <= slot;
         end
      end
   end
endmodule

// File: tb/tb_tdm_mux4.sv
// Directed bench for tdm_mux4 (W=1): reset, rotation, backpressure, sparse traffic,
// back-to-back drain/load and reset while FULL. Honors TDM_MUX4_SKIP_EN for sparse traffic.
module tb_tdm_mux4;
   logic       clk;
   logic       rst;
   logic [3:0] in_data;
   logic [3:0] in_valid;
   logic [3:0] in_ready;
   logic [0:0] out_data;
   logic [1:0] out_sel;
   logic       out_valid;
   logic       out_ready;

   int checks = 0;
   int errors = 0;

   tdm_mux4 #(.W(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Rotation with all channels valid, data 4'b1010.
   logic [1:0] rot_sel [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
   logic       rot_dat [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [3:0] rot_rdy [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`ifdef TDM_MUX4_SKIP_EN
   logic       sp_vld  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`else
   logic       sp_vld  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

   initial begin
      rst       = 1'b1;
      in_valid  = 4'hF;
      in_data   = 4'b1010;
      out_ready = 1'b1;

      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_sel",   32'(out_sel),   32'd0);
         chk("rst_out_data",  32'(out_data),  32'd0);
         chk("rst_in_ready",  32'(in_ready),  32'b0001);
      end
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         tick();
         chk("rot_valid", 32'(out_valid), 32'd1);
         chk("rot_sel",   32'(out_sel),   32'(rot_sel[i]));
         chk("rot_data",  32'(out_data),  32'(rot_dat[i]));
         chk("rot_ready", 32'(in_ready),  32'(rot_rdy[i]));
      end

      // FULL with out_sel=2; stall three cycles. New ch2 data must not leak in.
      out_ready = 1'b0;
      in_data   = 4'b1100;
      #1;
      chk("bp_ready_low", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_sel",   32'(out_sel),   32'd2);
         chk("bp_data",  32'(out_data),  32'd0);
         chk("bp_ready", 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'b1000);
      tick();
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_sel",   32'(out_sel),   32'd3);
      chk("b2b_data",  32'(out_data),  32'd1);

      // Sparse: only channel 2 valid (ptr is 0 here).
      in_valid = 4'b0100;
      in_data  = 4'b0100;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("sparse_valid", 32'(out_valid), 32'(sp_vld[i]));
         if (sp_vld[i]) begin
            chk("sparse_sel",  32'(out_sel),  32'd2);
            chk("sparse_data", 32'(out_data), 32'd1);
         end
      end

      // Reset while FULL and stalled: word dropped, pointer back to channel 0.
      out_ready = 1'b0;
      in_valid  = 4'hF;
      rst       = 1'b1;
      tick();
      chk("rstf_valid", 32'(out_valid), 32'd0);
      chk("rstf_sel",   32'(out_sel),   32'd0);
      chk("rstf_ready", 32'(in_ready),  32'b0001);
      rst = 1'b0;
      tick();
      chk("rstf_first_valid", 32'(out_valid), 32'd1);
      chk("rstf_first_sel",   32'(out_sel),   32'd0);
      chk("rstf_first_data",  32'(out_data),  32'd0);
      chk("rstf_hold_ready",  32'(in_ready),  32'd0);
      tick();
      chk("rstf_hold_valid", 32'(out_valid), 32'd1);
      chk("rstf_hold_sel",   32'(out_sel),   32'd0);
      out_ready = 1'b1;
      #1;
      chk("rstf_next_ready", 32'(in_ready), 32'b0010);
      tick();
      chk("rstf_next_sel", 32'(out_sel), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
